// File: rtl/sdram_pkg.sv
// Shared widths and arbiter state encoding for the SDRAM front end.
package sdram_pkg;

  localparam int unsigned SDRAM_ADDR_WIDTH = 25;
  localparam int unsigned SDRAM_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StDone  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sdram_rr_pick.sv
// Combinational two-way pick: a lone requester wins, ties go to the client
// other than last_grant when round_robin is set, else to client 0.
module sdram_rr_pick (
  input  logic [1:0] request,
  input  logic       last_grant,
  input  logic       round_robin,
  output logic       valid,
  output logic       grant_index
);

  always_comb begin
    valid = |request;
    case (request)
      2'b11:   grant_index = round_robin ? ~last_grant : 1'b0;
      2'b10:   grant_index = 1'b1;
      default: grant_index = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter owning the controller's 4-phase command/response handshake.
// The granted request is latched and held toward the controller for the whole transaction.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = SDRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = SDRAM_DATA_WIDTH,
  parameter bit          ROUND_ROBIN = 1'b1
) (
  input  logic                    osc_50,
  input  logic                    reset_50m_n,
  input  logic [1:0]              client_command,
  input  logic [1:0]              client_write,
  input  logic [2*ADDR_WIDTH-1:0] client_address,
  input  logic [2*DATA_WIDTH-1:0] client_data_write,
  output logic [1:0]              client_response,
  output logic [DATA_WIDTH-1:0]   client_data_read,
  output logic                    sdram_command,
  input  logic                    sdram_response,
  output logic                    sdram_write,
  output logic [ADDR_WIDTH-1:0]   sdram_address,
  output logic [DATA_WIDTH-1:0]   sdram_data_write,
  input  logic [DATA_WIDTH-1:0]   sdram_data_read
);

  arb_state_e state_q;
  logic       grant_q;
  logic       last_grant_q;
  logic       pick_valid;
  logic       pick_index;

  sdram_rr_pick u_pick (
    .request     (client_command),
    .last_grant  (last_grant_q),
    .round_robin (ROUND_ROBIN),
    .valid       (pick_valid),
    .grant_index (pick_index)
  );

  always_ff @(posedge osc_50 or negedge reset_50m_n) begin
    if (!reset_50m_n) begin
      state_q          <= StIdle;
      grant_q          <= 1'b0;
      last_grant_q     <= 1'b1;
      sdram_command    <= 1'b0;
      sdram_write      <= 1'b0;
      sdram_address    <= '0;
      sdram_data_write <= '0;
      client_response  <= 2'b00;
      client_data_read <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // A high sdram_response here is the tail of a transaction cut short by reset.
          if (!sdram_response && pick_valid) begin
            grant_q          <= pick_index;
            last_grant_q     <= pick_index;
            sdram_command    <= 1'b1;
            sdram_write      <= client_write[pick_index];
            sdram_address    <= client_address[pick_index*ADDR_WIDTH +: ADDR_WIDTH];
            sdram_data_write <= client_data_write[pick_index*DATA_WIDTH +: DATA_WIDTH];
            state_q          <= StIssue;
          end
        end
        StIssue: begin
          if (sdram_response) begin
            if (!sdram_write) client_data_read <= sdram_data_read;
            sdram_command   <= 1'b0;
            client_response <= grant_q ? 2'b10 : 2'b01;
            state_q         <= StDone;
          end
        end
        StDone: begin
          if (!client_command[grant_q] && !sdram_response) begin
            client_response <= 2'b00;
            state_q         <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
